// File: rtl/seq_decoder.sv
// seq_decoder: registered N-to-2^N one-hot decoder with enable/hold.
// Optional auto-scan mode (define SEQ_DECODER_SCAN_EN) steps the active
// output through every position, holding each for a latched dwell count.
module seq_decoder #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  valid,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;

  // Single set bit at position i.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef SEQ_DECODER_SCAN_EN
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   idx_inc;

  assign idx_inc = idx_q + 1'b1;

  // Next-state and next-output logic; en=0 holds everything except wrap.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    dwell_lat_d = dwell_lat_q;
    wrap_d      = 1'b0;
    if (en) begin
      unique case (state_q)
        S_IDLE, S_DIRECT: begin
          idx_d   = sel;
          y_d     = onehot(sel);
          valid_d = 1'b1;
          if (mode) begin
            // Scan entry: dwell is captured here and ignored until next entry.
            state_d     = S_SCAN;
            dwell_lat_d = dwell;
            cnt_d       = '0;
          end else begin
            state_d = S_DIRECT;
          end
        end
        S_SCAN: begin
          if (!mode) begin
            state_d = S_DIRECT;
            idx_d   = sel;
            y_d     = onehot(sel);
            cnt_d   = '0;
          end else if (cnt_q == dwell_lat_q) begin
            cnt_d  = '0;
            idx_d  = idx_inc;
            y_d    = onehot(idx_inc);
            wrap_d = (idx_q == {SEL_W{1'b1}});
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Scan-only registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dwell_lat_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dwell_lat_q <= dwell_lat_d;
      wrap_q      <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`else
  // Scan controls have no effect in this build.
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{mode, dwell};

  // Next-state and next-output logic for the plain registered decoder.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (en) begin
      state_d = S_DIRECT;
      idx_d   = sel;
      y_d     = onehot(sel);
      valid_d = 1'b1;
    end
  end

  assign wrap = 1'b0;
`endif

  // State and decoded-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_seq_decoder.sv
module tb_seq_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] dwell;
    logic [3:0] y;
    logic [1:0] idx;
    logic       valid;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;
    logic done_reg = 1'b0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] dwell;
        logic [3:0] exp_y;
        logic [1:0] exp_idx;
        logic       exp_valid;
        logic       exp_wrap;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    seq_decoder #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .dwell (dwell),
        .y     (y),
        .idx   (idx),
        .valid (valid),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        if (!done_reg) begin
            n_fail++;
            $display("FAIL timeout: test did not complete within 100000 time units");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    function automatic void add(input logic r, input logic e, input logic m,
                                input logic [1:0] s, input logic [3:0] d,
                                input logic [3:0] ey, input logic [1:0] ei,
                                input logic ev, input logic ew, input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sel = s; v.dwell = d;
        v.exp_y = ey; v.exp_idx = ei; v.exp_valid = ev; v.exp_wrap = ew;
        v.name = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        sb_t  s;
        logic [7:0] act;

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; dwell = '0;

        repeat (2) @(posedge clk);
        #1;
        act = {y, idx, valid, wrap};
        n_checks++;
        if (act !== 8'b0000_00_0_0) begin
            n_fail++;
            $display("FAIL reset_state: got y=%b idx=%0d valid=%b wrap=%b, want y=0000 idx=0 valid=0 wrap=0",
                     act[7:4], act[3:2], act[1], act[0]);
        end else begin
            $display("ok   reset_state: y=%b idx=%0d valid=%b wrap=%b",
                     act[7:4], act[3:2], act[1], act[0]);
        end

        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, "reset0");
        add(1, 1, 1, 3, 0, 4'b0000, 0, 0, 0, "reset1");
        for (int i = 0; i < 5; i++)
            add(0, 0, i[0], 2'(i), 4'(i), 4'b0000, 0, 0, 0, "idle_hold");
`ifdef SEQ_DECODER_SCAN_EN
        add(0, 1, 0, 0, 0, 4'b0001, 0, 1, 0, "direct0");
        add(0, 1, 0, 1, 0, 4'b0010, 1, 1, 0, "direct1");
        add(0, 1, 0, 2, 0, 4'b0100, 2, 1, 0, "direct2");
        add(0, 1, 0, 3, 0, 4'b1000, 3, 1, 0, "direct3");
        add(0, 1, 0, 2, 0, 4'b0100, 2, 1, 0, "direct2b");
        for (int i = 0; i < 6; i++)
            add(0, 0, i[0], 2'(i), 0, 4'b0100, 2, 1, 0, "en0_hold");
        add(0, 1, 1, 3, 1, 4'b1000, 3, 1, 0, "scan_entry");
        add(0, 1, 1, 0, 5, 4'b1000, 3, 1, 0, "scan_dwell");
        add(0, 1, 1, 0, 5, 4'b0001, 0, 1, 1, "scan_wrap");
        add(0, 0, 1, 0, 5, 4'b0001, 0, 1, 0, "wrap_en0");
        add(0, 1, 1, 0, 5, 4'b0001, 0, 1, 0, "scan_dwell0");
        add(0, 1, 1, 0, 5, 4'b0010, 1, 1, 0, "scan_step1");
        add(0, 1, 1, 0, 5, 4'b0010, 1, 1, 0, "scan_dwell1");
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 0, 5, 4'b0010, 1, 1, 0, "scan_stretch");
        add(0, 1, 1, 0, 5, 4'b0100, 2, 1, 0, "scan_step2");
        add(0, 1, 1, 0, 5, 4'b0100, 2, 1, 0, "scan_dwell2");
        add(0, 1, 1, 0, 5, 4'b1000, 3, 1, 0, "scan_step3");
        add(0, 1, 1, 0, 5, 4'b1000, 3, 1, 0, "scan_dwell3");
        add(0, 1, 1, 0, 5, 4'b0001, 0, 1, 1, "scan_wrap2");
        add(0, 1, 1, 0, 5, 4'b0001, 0, 1, 0, "scan_after_wrap");
        add(0, 1, 1, 0, 5, 4'b0010, 1, 1, 0, "scan_at1");
        add(0, 1, 0, 3, 5, 4'b1000, 3, 1, 0, "to_direct");
        add(0, 1, 1, 2, 0, 4'b0100, 2, 1, 0, "reenter");
        add(0, 1, 1, 2, 0, 4'b1000, 3, 1, 0, "d0_step3");
        add(0, 1, 1, 2, 0, 4'b0001, 0, 1, 1, "d0_wrap");
        add(1, 1, 1, 2, 0, 4'b0000, 0, 0, 0, "rst_midscan");
        add(0, 1, 1, 1, 0, 4'b0010, 1, 1, 0, "idle_to_scan");
        add(0, 1, 1, 1, 0, 4'b0100, 2, 1, 0, "d0_step2");
        add(0, 0, 0, 0, 0, 4'b0100, 2, 1, 0, "mode_en0");
        add(0, 1, 1, 0, 0, 4'b1000, 3, 1, 0, "d0_step3b");
        add(0, 1, 0, 0, 0, 4'b0001, 0, 1, 0, "direct_pre");
        add(0, 1, 1, 0, 15, 4'b0001, 0, 1, 0, "dmax_entry");
        for (int i = 0; i < 15; i++)
            add(0, 1, 1, 0, 0, 4'b0001, 0, 1, 0, "dmax_hold");
        add(0, 1, 1, 0, 0, 4'b0010, 1, 1, 0, "dmax_step");
`else
        add(0, 1, 0, 0, 0, 4'b0001, 0, 1, 0, "direct0");
        add(0, 1, 0, 1, 0, 4'b0010, 1, 1, 0, "direct1");
        add(0, 1, 0, 2, 0, 4'b0100, 2, 1, 0, "direct2");
        add(0, 1, 0, 3, 0, 4'b1000, 3, 1, 0, "direct3");
        add(0, 1, 0, 2, 0, 4'b0100, 2, 1, 0, "direct2b");
        for (int i = 0; i < 6; i++)
            add(0, 0, i[0], 2'(i), 0, 4'b0100, 2, 1, 0, "en0_hold");
        for (int i = 0; i < 8; i++)
            add(0, 1, 1, 1, 0, 4'b0010, 1, 1, 0, "mode1_ignored");
        add(0, 1, 1, 3, 15, 4'b1000, 3, 1, 0, "mode1_sel3");
        add(1, 1, 1, 3, 0, 4'b0000, 0, 0, 0, "rst_again");
        add(0, 0, 1, 3, 0, 4'b0000, 0, 0, 0, "idle_en0");
        add(0, 1, 1, 0, 0, 4'b0001, 0, 1, 0, "idle_to_direct");
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            en    = vecs[i].en;
            mode  = vecs[i].mode;
            sel   = vecs[i].sel;
            dwell = vecs[i].dwell;
            s.exp  = {vecs[i].exp_y, vecs[i].exp_idx, vecs[i].exp_valid, vecs[i].exp_wrap};
            s.name = vecs[i].name;
            sb.push_back(s);
            @(posedge clk);
            #1;
            s   = sb.pop_front();
            act = {y, idx, valid, wrap};
            n_checks++;
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL %0d %s: got y=%b idx=%0d valid=%b wrap=%b, want y=%b idx=%0d valid=%b wrap=%b",
                         i, s.name, act[7:4], act[3:2], act[1], act[0],
                         s.exp[7:4], s.exp[3:2], s.exp[1], s.exp[0]);
            end else begin
                $display("ok   %0d %s: y=%b idx=%0d valid=%b wrap=%b",
                         i, s.name, act[7:4], act[3:2], act[1], act[0]);
            end
        end

        done_reg = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_decoder.md
# seq_decoder

Registered, parametrised N-to-2^N one-hot decoder that replaces the fixed combinational 2-to-4 decoder in designs that need clocked outputs. It adds an enable, a hold behaviour, and an optional auto-scan mode that steps the active output through all positions with a programmable dwell. It drives one-hot strobes such as row selects, channel enables and mux selects from a single synchronous clock domain.

## Interface
- SEL_W, 2, select width; legal 1..6; output width OUT_W = 2**SEL_W (derived localparam, not overridable)
- DWELL_W, 4, width of dwell-count input
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  advance/update enable; low = hold all state and outputs
- mode  input  1  0 = direct decode, 1 = scan (scan only with SEQ_DECODER_SCAN_EN)
- sel  input  SEL_W  index to decode (direct) / scan start index
- dwell  input  DWELL_W  scan: cycles per position minus one, latched at scan entry
- y  output  OUT_W  registered one-hot output; y[i] high when index i active
- idx  output  SEL_W  binary index of the active output
- valid  output  1  high when y holds a decoded value (exactly one bit set)
- wrap  output  1  one-cycle pulse when scan steps from OUT_W-1 to 0

## Operation
- Reset: one clock, one reset; reset is synchronous and active-high. On a rising clk edge with rst=1: y=0, idx=0, valid=0, wrap=0, dwell counter=0, latched dwell=0, state=IDLE. rst overrides en and mode.
- States: IDLE, DIRECT, SCAN.
- IDLE: y=0, valid=0. en=1 and mode=0 -> DIRECT; en=1 and mode=1 -> SCAN. In both cases idx<=sel, y<=onehot(sel), valid<=1.
- DIRECT: each edge with en=1 and mode=0: idx<=sel, y<=onehot(sel). en=1 and mode=1 -> SCAN with idx<=sel, y<=onehot(sel), dwell latched, dwell counter<=0.
- SCAN: each edge with en=1, dwell counter increments. When counter == latched dwell, counter<=0 and idx<=idx+1 modulo OUT_W, y<=onehot(idx+1). On the step from OUT_W-1 to 0, wrap=1 for that cycle only. en=1 and mode=0 -> DIRECT: idx<=sel, y<=onehot(sel), counter cleared, wrap=0.
- en=0 in any state: y, idx, valid, counter and state hold. wrap is forced to 0.
- Once it leaves IDLE, valid stays 1 and y stays one-hot until rst.
- Arithmetic: idx increment is SEL_W-bit unsigned with natural wrap. The dwell counter is DWELL_W bits. dwell=0 steps every enabled cycle. dwell=2**DWELL_W-1 holds each position for 2**DWELL_W enabled cycles.

## Timing
- Latency: sel to y/idx is 1 clock (sampled on the edge with en=1, visible after that edge). There is no combinational path from inputs to outputs.
- Scan position period: (latched dwell + 1) enabled cycles. Disabled cycles stretch the period and do not count.
- The scan entry edge itself shows onehot(sel). The first step occurs dwell+1 enabled edges later.
- Changes to dwell during SCAN are ignored until the next scan entry.
- mode change with en=0 has no effect until the next en=1 edge.
- rst asserted mid-scan: outputs are at reset values after that edge. The next enabled edge re-enters from IDLE.

## Configuration
- SEQ_DECODER_SCAN_EN defined: SCAN state, dwell counter, dwell latch and wrap logic are compiled in, as described above.
- Not defined: mode and dwell are ignored (treated as mode=0), there is no SCAN state, and wrap is tied to 0. The block is then a registered decoder with enable and hold only.

## Test plan
- Reset/idle: rst=1 for 2 cycles, then rst=0, en=0 for 5 cycles -> y=0000, idx=0, valid=0, wrap=0 throughout.
- Direct decode, SEL_W=2: en=1, mode=0, sel=0,1,2,3 on successive edges -> y=0001,0010,0100,1000 each one cycle after its sel, valid=1.
- Hold: direct with sel=2 (y=0100), then en=0 while sel toggles 0..3 for 6 cycles -> y stays 0100, idx=2.
- Scan with dwell (macro defined): en=1, mode=1, sel=3, dwell=1 -> y=1000 for 2 cycles, then 0001 with wrap=1 for one cycle, then 0010 after 2 more cycles. en=0 for 3 cycles mid-position adds exactly 3 cycles to that position.
- Mode switch and reset mid-scan: scanning at idx=1, assert mode=0 with sel=3 -> next edge y=1000, wrap=0. Re-enter scan, assert rst for one edge -> y=0, valid=0, idx=0.
- Macro undefined: en=1, mode=1, dwell=0, sel=1 held for 8 cycles -> y=0010 constant, wrap never asserted.
